// File: rtl/ntt_pkg.sv
// ntt_pkg: shared widths, latencies and result record for the NTT butterfly datapath
package ntt_pkg;
  localparam int DW = 17;
  localparam int Q_DEFAULT = 7681;
  localparam int MUL_LAT = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W = 8;
  typedef struct packed {
    logic [DW-1:0]    x;
    logic [DW-1:0]    y;
    logic [TAG_W-1:0] tag;
  } bfly_res_t;
endpackage

// File: rtl/butterfly_out_fifo.sv
// butterfly_out_fifo: synchronous show-ahead FIFO of butterfly results with occupancy count
module butterfly_out_fifo
  import ntt_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  bfly_res_t                  wr_data,
  input  logic                       rd_en,
  output bfly_res_t                  rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  bfly_res_t mem [DEPTH];
  logic [AW:0] wp, rp;
  logic full, do_rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign do_rd = rd_en && !empty;
  // Head reads as zero when empty so idle outputs stay clean.
  assign rd_data = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) begin
        mem[wp[AW-1:0]] <= wr_data;
        wp <= wp + 1'b1;
      end
      if (do_rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!reset) assert (!(wr_en && full && !do_rd));
endmodule

// File: rtl/ntt_butterfly_addsub.sv
// ntt_butterfly_addsub: aligns a with the multiplier product, forms (a+p) mod Q and (a-p) mod Q, buffers with credit flow control
module ntt_butterfly_addsub #(
  parameter int DW         = ntt_pkg::DW,
  parameter int MUL_LAT    = ntt_pkg::MUL_LAT,
  parameter int FIFO_DEPTH = ntt_pkg::FIFO_DEPTH,
  parameter int TAG_W      = ntt_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    Q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    a,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             prod_valid,
  input  logic [DW-1:0]    prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    x_out,
  output logic [DW-1:0]    y_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             align_err
);
  import ntt_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [MUL_LAT-1:0] dl_v;
  logic [DW-1:0] dl_a [MUL_LAT];
  logic [TAG_W-1:0] dl_t [MUL_LAT];
  logic accept, tail_v, join_v, drop_acc, pop, s1_v, s2_v, empty;
  logic [DW-1:0] s1_a, s1_p;
  logic [TAG_W-1:0] s1_t;
  logic [DW:0] s1_sum;
  logic [CW-1:0] cnt, cnt_nxt, fifo_cnt;
  bfly_res_t s2_r, head;
  assign accept = in_valid && in_ready;
  assign tail_v = dl_v[MUL_LAT-1];
  assign join_v = tail_v && prod_valid;
  assign drop_acc = tail_v && !prod_valid;
  assign pop = out_valid && out_ready;
  assign cnt_nxt = cnt + CW'(accept) - CW'(pop) - CW'(drop_acc);
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_v      <= '0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      align_err <= 1'b0;
    end else begin
      dl_v      <= {dl_v[MUL_LAT-2:0], accept};
      s1_v      <= join_v;
      s2_v      <= s1_v;
      cnt       <= cnt_nxt;
      in_ready  <= cnt_nxt < CW'(FIFO_DEPTH);
      align_err <= align_err || (tail_v != prod_valid);
    end
  end
  // Datapath registers need no reset: the valid bits above qualify them.
  always_ff @(posedge clk) begin
    dl_a[0] <= a;
    dl_t[0] <= tag_in;
    for (int i = 1; i < MUL_LAT; i++) begin
      dl_a[i] <= dl_a[i-1];
      dl_t[i] <= dl_t[i-1];
    end
    s1_a     <= dl_a[MUL_LAT-1];
    s1_p     <= prod;
    s1_t     <= dl_t[MUL_LAT-1];
    s1_sum   <= {1'b0, dl_a[MUL_LAT-1]} + {1'b0, prod};
    s2_r.x   <= s1_sum >= {1'b0, Q} ? DW'(s1_sum - {1'b0, Q}) : DW'(s1_sum);
    s2_r.y   <= s1_a >= s1_p ? s1_a - s1_p : s1_a - s1_p + Q;
    s2_r.tag <= s1_t;
  end
  butterfly_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s2_v),
    .wr_data (s2_r),
    .rd_en   (out_ready),
    .rd_data (head),
    .empty   (empty),
    .count   (fifo_cnt)
  );
  assign out_valid = !empty;
  assign x_out = head.x;
  assign y_out = head.y;
  assign tag_out = head.tag;
  // Every buffered result still holds the credit of its accepted beat.
  always_ff @(posedge clk)
    if (!reset) assert (fifo_cnt <= cnt);
endmodule

// File: tb/tb_ntt_butterfly_addsub.sv
// tb_ntt_butterfly_addsub: directed self-checking bench with a fixed-latency multiplier stand-in
module tb_ntt_butterfly_addsub;
  import ntt_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] q = 17'd7681;
  logic in_valid, in_ready, prod_valid, out_valid, out_ready, align_err;
  logic [DW-1:0] a, prod, x_out, y_out, pa, extra_p;
  logic [TAG_W-1:0] tag_in, tag_out;
  logic kill, extra;
  logic [MUL_LAT-1:0] mv, mk;
  logic [DW-1:0] mp [MUL_LAT];
  int passed = 0, total = 0, fails = 0;
  ntt_butterfly_addsub dut (
    .clk(clk), .reset(reset), .Q(q), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .tag_in(tag_in), .prod_valid(prod_valid), .prod(prod),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
    .tag_out(tag_out), .align_err(align_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reset) begin
      mv <= '0;
      mk <= '0;
    end else begin
      mv <= {mv[MUL_LAT-2:0], in_valid && in_ready};
      mk <= {mk[MUL_LAT-2:0], kill};
    end
    mp[0] <= pa;
    for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
  end
  assign prod_valid = (mv[MUL_LAT-1] && !mk[MUL_LAT-1]) || extra;
  assign prod = extra ? extra_p : mp[MUL_LAT-1];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_arrive"}, 32'(out_valid), 1);
  endtask
  task automatic pop_check(input string tag, input int ex, input int ey, input int et);
    wait_out(tag);
    chk({tag, "_x"}, 32'(x_out), 32'(ex));
    chk({tag, "_y"}, 32'(y_out), 32'(ey));
    chk({tag, "_tag"}, 32'(tag_out), 32'(et));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic send(input int av, input int pv, input int tv, input logic k);
    in_valid = 1'b1;
    a = DW'(av);
    pa = DW'(pv);
    tag_in = TAG_W'(tv);
    kill = k;
    tick();
    in_valid = 1'b0;
    kill = 1'b0;
  endtask
  task automatic fill_count(output int n);
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 1;
    pa = 1;
    n = 0;
    repeat (12) begin
      if (in_ready) n++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    out_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int n, s, r, cyc, seen, ex, ey;
    logic got5;
    in_valid = 0; out_ready = 0; a = 0; tag_in = 0; pa = 0; kill = 0; extra = 0; extra_p = 0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_x", 32'(x_out), 0);
    chk("rst_y", 32'(y_out), 0);
    chk("rst_tag", 32'(tag_out), 0);
    chk("rst_align", 32'(align_err), 0);
    reset = 1'b0;
    tick();
    send(100, 50, 1, 0);
    n = 0;
    while (!prod_valid && n < 20) begin
      tick();
      n++;
    end
    chk("pv_seen", 32'(prod_valid), 1);
    tick(); tick();
    chk("lat_k2", 32'(out_valid), 0);
    tick();
    chk("lat_k3", 32'(out_valid), 1);
    pop_check("b100", 150, 50, 1);
    send(7000, 1000, 2, 0);
    send(10, 20, 3, 0);
    send(0, 0, 4, 0);
    pop_check("b7000", 319, 6000, 2);
    pop_check("b10", 30, 7671, 3);
    pop_check("b0", 0, 0, 4);
    n = 0;
    in_valid = 1'b1;
    repeat (10) begin
      a = DW'(n + 5);
      pa = 1;
      tag_in = TAG_W'(n);
      if (in_ready) n++;
      tick();
    end
    chk("bp_accepted", 32'(n), 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    got5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_out("bp_pop");
      chk("bp_tag", 32'(tag_out), 32'(i));
      chk("bp_x", 32'(x_out), 32'(i + 6));
      if (in_ready && in_valid) got5 = 1'b1;
      tick();
      if (got5) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    chk("bp_5th_accept", 32'(got5), 1);
    pop_check("bp_5th", 10, 8, 4);
    chk("bp_ready_back", 32'(in_ready), 1);
    s = 0; r = 0; cyc = 0;
    out_ready = 1'b1;
    while (r < 32 && cyc < 400) begin
      if (out_valid) begin
        ex = (r * 200 + 3000) % 7681;
        ey = (r * 200 - 3000 + 7681) % 7681;
        chk("str_x", 32'(x_out), 32'(ex));
        chk("str_y", 32'(y_out), 32'(ey));
        chk("str_tag", 32'(tag_out), 32'(r));
        r++;
      end
      in_valid = s < 32;
      a = DW'(s * 200);
      pa = 3000;
      tag_in = TAG_W'(s);
      if (in_valid && in_ready) s++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("str_count", 32'(r), 32);
    chk("str_align", 32'(align_err), 0);
    fill_count(n);
    chk("str_credit", 32'(n), 4);
    send(1, 1, 10, 0);
    send(2, 1, 11, 1);
    send(3, 1, 12, 0);
    pop_check("drop_a", 2, 0, 10);
    pop_check("drop_c", 4, 2, 12);
    repeat (5) tick();
    chk("drop_empty", 32'(out_valid), 0);
    chk("drop_align", 32'(align_err), 1);
    fill_count(n);
    chk("drop_credit", 32'(n), 4);
    chk("drop_sticky", 32'(align_err), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("xtra_pre_align", 32'(align_err), 0);
    extra = 1'b1;
    extra_p = 5;
    tick();
    extra = 1'b0;
    repeat (8) tick();
    chk("xtra_align", 32'(align_err), 1);
    chk("xtra_empty", 32'(out_valid), 0);
    fill_count(n);
    chk("xtra_credit", 32'(n), 4);
    send(5, 1, 20, 0);
    send(6, 1, 21, 0);
    repeat (10) tick();
    chk("mid_fifo_full", 32'(out_valid), 1);
    send(7, 1, 22, 0);
    send(8, 1, 23, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    chk("mrst_align", 32'(align_err), 0);
    chk("mrst_x", 32'(x_out), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (15) begin
      if (out_valid) seen++;
      tick();
    end
    out_ready = 1'b0;
    chk("mrst_no_stale", 32'(seen), 0);
    send(40, 50, 30, 0);
    pop_check("post_rst", 90, 7671, 30);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
